// File: rtl/gclk_ctrl_pkg.sv
// Shared types for the steady-window checker: FSM states, default sizes and
// the result record layout.
package gclk_ctrl_pkg;

   localparam int unsigned NCH_DEF = 4;
   localparam int unsigned LW_DEF  = 8;
   localparam int unsigned CW_DEF  = $clog2(NCH_DEF);

   typedef enum logic [1:0] {IDLE, ARM, CHECK, REPORT} chk_state_e;

   typedef struct packed {
      logic [CW_DEF-1:0] chan;
      logic              pass;
      logic [LW_DEF-1:0] off;
   } res_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; the pointer moves past the winner only on an enabled grant.
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt_c,
   output logic [PW-1:0] gnt_idx_c
);

   logic [PW-1:0] ptr;
   logic          found;
   int unsigned   k;

   // Scan from ptr upward, wrapping, and take the first active request
   always_comb begin
      gnt_c     = '0;
      gnt_idx_c = '0;
      found     = 1'b0;
      k         = 0;
      if (en) begin
         for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr) + i) % N;
            if (!found && req[PW'(k)]) begin
               found           = 1'b1;
               gnt_c[PW'(k)]   = 1'b1;
               gnt_idx_c       = PW'(k);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (32'(gnt_idx_c) == N - 1) ? '0 : gnt_idx_c + PW'(1);
      end
   end

endmodule

// File: rtl/gclk_steady_window_ctrl.sv
// Shared steady-window checker: arbitrates NCH window requests and reports
// whether the granted signal held steady for the requested number of cycles.
module gclk_steady_window_ctrl
   import gclk_ctrl_pkg::*;
#(
   parameter  int unsigned NCH = NCH_DEF,
   parameter  int unsigned LW  = LW_DEF,
   localparam int unsigned CW  = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    sig,
   input  logic [NCH-1:0]    req_valid,
   input  logic [NCH*LW-1:0] req_len,
   output logic [NCH-1:0]    req_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CW-1:0]     res_chan,
   output logic              res_pass,
   output logic [LW-1:0]     res_fail_off,
   output logic              busy
);

   chk_state_e    state_q, state_d;
   logic [NCH-1:0] sig_q;
   logic           ref_q;
   logic [LW-1:0]  cnt_q;
   logic [LW-1:0]  len_q;
   logic [CW-1:0]  chan_q;
   logic [CW-1:0]  gnt_idx;
   logic           arb_en;
   logic           grant;
   logic           cur_sig;
   logic           res_load;
   logic           pass_d;
   logic [LW-1:0]  off_d;
   logic [LW-1:0]  len_arr [NCH];

   // Grants are held off while in reset so every output reads 0 there
   assign arb_en  = (state_q == IDLE) && rst_n;
   assign grant   = |req_ready;
   assign cur_sig = sig_q[chan_q];

   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         len_arr[i] = req_len[i*LW +: LW];
      end
   end

   rr_arbiter #(.N(NCH)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .en        (arb_en),
      .gnt_c     (req_ready),
      .gnt_idx_c (gnt_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      res_load = 1'b0;
      pass_d   = 1'b0;
      off_d    = '0;
      case (state_q)
         IDLE: begin
            if (grant) state_d = ARM;
         end
         ARM: begin
            if (len_q == '0) begin
               state_d  = REPORT;
               res_load = 1'b1;
               pass_d   = 1'b1;
            end else begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (cur_sig != ref_q) begin
               state_d  = REPORT;
               res_load = 1'b1;
               off_d    = cnt_q;
            end else if (cnt_q == len_q) begin
               state_d  = REPORT;
               res_load = 1'b1;
               pass_d   = 1'b1;
            end
         end
         REPORT: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered result/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q        <= '0;
         ref_q        <= 1'b0;
         cnt_q        <= '0;
         len_q        <= '0;
         chan_q       <= '0;
         res_valid    <= 1'b0;
         res_chan     <= '0;
         res_pass     <= 1'b0;
         res_fail_off <= '0;
         busy         <= 1'b0;
      end else begin
         sig_q <= sig;
         busy  <= (state_d != IDLE);
         if (grant) begin
            chan_q <= gnt_idx;
            len_q  <= len_arr[gnt_idx];
         end
         if (state_q == ARM) begin
            ref_q <= cur_sig;
            cnt_q <= LW'(1);
         end else if (state_q == CHECK && !res_load) begin
            cnt_q <= cnt_q + LW'(1);
         end
         if (res_load) begin
            res_valid    <= 1'b1;
            res_chan     <= chan_q;
            res_pass     <= pass_d;
            res_fail_off <= off_d;
         end else if (state_q == REPORT && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gclk_steady_window_ctrl.sv
// Directed bench for gclk_steady_window_ctrl: table of single-window vectors
// plus hand-written contention, backpressure and mid-window reset sequences.
module tb_gclk_steady_window_ctrl;
   import gclk_ctrl_pkg::*;

   localparam int unsigned NCH = 4;
   localparam int unsigned LW  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH-1:0]    sig = '0;
   logic [NCH-1:0]    req_valid = '0;
   logic [NCH*LW-1:0] req_len = '0;
   logic [NCH-1:0]    req_ready;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [1:0]        res_chan;
   logic              res_pass;
   logic [LW-1:0]     res_fail_off;
   logic              busy;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   gclk_steady_window_ctrl #(.NCH(NCH), .LW(LW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sig          (sig),
      .req_valid    (req_valid),
      .req_len      (req_len),
      .req_ready    (req_ready),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_chan     (res_chan),
      .res_pass     (res_pass),
      .res_fail_off (res_fail_off),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int onehot_idx(input logic [NCH-1:0] v);
      int r = -1;
      for (int i = 0; i < NCH; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Continuous protocol checks: one-hot grant, result held under backpressure
   logic          pv_valid = 1'b0, pv_ready = 1'b0, p_rst = 1'b0;
   res_t          pv_res;
   always @(negedge clk) begin
      if (!$onehot0(req_ready)) begin
         n_err++;
         $display("FAIL onehot_req_ready: got %b", req_ready);
      end
      if (rst_n && p_rst && pv_valid && !pv_ready) begin
         if (!res_valid || {res_chan, res_pass, res_fail_off} !== pv_res) begin
            n_err++;
            $display("FAIL res_stable: got v=%b %h expected v=1 %h", res_valid,
                     {res_chan, res_pass, res_fail_off}, pv_res);
         end
      end
      pv_valid = res_valid;
      pv_ready = res_ready;
      p_rst    = rst_n;
      pv_res   = {res_chan, res_pass, res_fail_off};
   end

   // Wait (bounded) for res_valid; returns the cycle it was seen
   task automatic wait_res(input string name, output int r, output bit got);
      got = 1'b0;
      r   = 0;
      for (int k = 0; k < 400; k++) begin
         #1;
         if (res_valid) begin
            got = 1'b1;
            r   = cyc;
            break;
         end
         tick;
      end
      chk({name, "_timeout"}, 32'(got), 32'd1);
   endtask

   task automatic accept;
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      #1;
      chk("accept_busy", 32'(busy), 32'd0);
      chk("accept_valid", 32'(res_valid), 32'd0);
   endtask

   typedef struct {
      int   ch;
      int   len;
      int   tog;   // cycle after grant whose sig change is applied; -1 = none
      res_t exp;
      int   lat;
   } vec_t;

   vec_t vecs[9];

   task automatic run_vec(input vec_t v);
      int g, r;
      bit got;
      req_len[v.ch*LW +: LW] = LW'(v.len);
      req_valid[v.ch] = 1'b1;
      #1;
      chk("v_grant", 32'(req_ready), 32'(1) << v.ch);
      g = cyc;
      if (v.tog == 0) sig[v.ch] = ~sig[v.ch];
      tick;
      req_valid[v.ch] = 1'b0;
      got = 1'b0;
      r   = 0;
      for (int k = 0; k < 400; k++) begin
         if (v.tog > 0 && cyc - g == v.tog) sig[v.ch] = ~sig[v.ch];
         #1;
         if (res_valid) begin
            got = 1'b1;
            r   = cyc;
            break;
         end
         tick;
      end
      chk("v_timeout", 32'(got), 32'd1);
      if (got) begin
         chk("v_latency", 32'(r - g), 32'(v.lat));
         chk("v_chan", 32'(res_chan), 32'(v.exp.chan));
         chk("v_pass", 32'(res_pass), 32'(v.exp.pass));
         chk("v_off", 32'(res_fail_off), 32'(v.exp.off));
         chk("v_busy", 32'(busy), 32'd1);
         accept;
      end
   endtask

   initial begin
      int g, r, ng, nr;
      bit got;
      int order[5];
      int rchan[5];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      res_t hold;

      // ch, len, tog, {chan, pass, off}, latency
      vecs[0] = '{1, 5,   -1, '{2'd1, 1'b1, 8'd0},   7};
      vecs[1] = '{2, 10,   4, '{2'd2, 1'b0, 8'd4},   6};
      vecs[2] = '{3, 0,   -1, '{2'd3, 1'b1, 8'd0},   2};
      vecs[3] = '{0, 3,    0, '{2'd0, 1'b1, 8'd0},   5};
      vecs[4] = '{1, 1,    1, '{2'd1, 1'b0, 8'd1},   3};
      vecs[5] = '{2, 4,    4, '{2'd2, 1'b0, 8'd4},   6};
      vecs[6] = '{3, 4,    5, '{2'd3, 1'b1, 8'd0},   6};
      vecs[7] = '{0, 255, 255, '{2'd0, 1'b0, 8'd255}, 257};
      vecs[8] = '{1, 255, -1, '{2'd1, 1'b1, 8'd0},   257};

      // Reset state, with requests pending
      req_valid = '1;
      @(posedge clk);
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_chan", 32'(res_chan), 32'd0);
      chk("rst_res_pass", 32'(res_pass), 32'd0);
      chk("rst_res_off", 32'(res_fail_off), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      req_valid = '0;
      tick;
      rst_n = 1'b1;
      tick;

      // Contention: all channels, len=1, consumer always ready
      for (int i = 0; i < NCH; i++) req_len[i*LW +: LW] = LW'(1);
      req_valid = '1;
      res_ready = 1'b1;
      ng = 0;
      nr = 0;
      for (int k = 0; k < 100; k++) begin
         #1;
         chk("rr_no_grant_busy", 32'(busy && (req_ready != '0)), 32'd0);
         if (req_ready != '0 && ng < 5) begin
            order[ng] = onehot_idx(req_ready);
            ng++;
         end
         if (res_valid && nr < 5) begin
            rchan[nr] = int'(res_chan);
            nr++;
         end
         tick;
         if (ng == 5) req_valid = '0;
         if (nr == 5) break;
      end
      res_ready = 1'b0;
      chk("rr_grants", 32'(ng), 32'd5);
      chk("rr_results", 32'(nr), 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
         chk("rr_res_chan", 32'(rchan[i]), 32'(exp_order[i]));
      end
      tick;

      // Single-window table
      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: ch2 result held 6 cycles while ch1 waits
      req_len[2*LW +: LW] = LW'(2);
      req_valid[2] = 1'b1;
      #1;
      chk("bp_grant", 32'(req_ready), 32'b0100);
      g = cyc;
      tick;
      req_valid[2] = 1'b0;
      req_len[1*LW +: LW] = LW'(1);
      req_valid[1] = 1'b1;
      wait_res("bp", r, got);
      chk("bp_latency", 32'(r - g), 32'd4);
      hold = '{2'd2, 1'b1, 8'd0};
      for (int k = 0; k < 6; k++) begin
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_fields", 32'({res_chan, res_pass, res_fail_off}), 32'(hold));
         chk("bp_busy", 32'(busy), 32'd1);
         chk("bp_no_grant", 32'(req_ready), 32'd0);
         tick;
         #1;
      end
      res_ready = 1'b1;
      chk("bp_hs_no_grant", 32'(req_ready), 32'd0);
      tick;
      res_ready = 1'b0;
      #1;
      chk("bp_grant_after_hs", 32'(req_ready), 32'b0010);
      g = cyc;
      tick;
      req_valid[1] = 1'b0;
      wait_res("bp2", r, got);
      chk("bp2_latency", 32'(r - g), 32'd3);
      chk("bp2_chan", 32'(res_chan), 32'd1);
      chk("bp2_pass", 32'(res_pass), 32'd1);
      accept;

      // Async reset mid-CHECK aborts the window and resets the pointer
      req_len[0*LW +: LW] = LW'(20);
      req_valid[0] = 1'b1;
      #1;
      chk("ar_grant", 32'(req_ready), 32'b0001);
      tick;
      req_valid[0] = 1'b0;
      for (int k = 0; k < 7; k++) tick;
      req_len[0*LW +: LW] = LW'(2);
      req_len[3*LW +: LW] = LW'(2);
      req_valid = 4'b1001;
      chk("ar_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("ar_req_ready", 32'(req_ready), 32'd0);
      chk("ar_res_valid", 32'(res_valid), 32'd0);
      chk("ar_res_chan", 32'(res_chan), 32'd0);
      chk("ar_res_pass", 32'(res_pass), 32'd0);
      chk("ar_res_off", 32'(res_fail_off), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      tick;
      chk("ar_hold_valid", 32'(res_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("ar_grant_ptr0", 32'(req_ready), 32'b0001);
      chk("ar_no_result", 32'(res_valid), 32'd0);
      g = cyc;
      tick;
      req_valid = '0;
      wait_res("ar2", r, got);
      chk("ar2_latency", 32'(r - g), 32'd4);
      chk("ar2_chan", 32'(res_chan), 32'd0);
      chk("ar2_pass", 32'(res_pass), 32'd1);
      accept;

      tick;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
